// File: rtl/adc_scan_avg.sv
// adc_scan_avg: periodic multi-channel ADC scan controller with averaging.
// Every PERIOD clocks (while enabled) it scans channels 0..N_CH-1. Each
// channel gets 2^AVG_LOG2 conversions. Their truncated mean is published into
// a per-channel result register. A conversion that gets no adc_ready within
// TIMEOUT clocks abandons that channel and raises a sticky timeout_err.
//
// Ports:
//   clk_clk, reset_reset       clock, synchronous active-high reset
//   enable                     scanning enabled (low aborts any scan)
//   adc_start, adc_chan        one-cycle conversion start and its channel
//   adc_ready, adc_data        conversion done strobe and its result
//   rd_chan, rd_data, rd_valid result readback (registered, 1-cycle latency)
//   sample_strobe, scan_done   publish pulse per channel, end-of-scan pulse
//   timeout_err, err_clr       sticky timeout flag and its clear
module adc_scan_avg #(
  parameter int DATA_W   = 10,
  parameter int N_CH     = 4,
  parameter int CH_BITS  = 2,
  parameter int AVG_LOG2 = 2,
  parameter int PERIOD   = 10000,
  parameter int TIMEOUT  = 255
) (
  input  logic               clk_clk,
  input  logic               reset_reset,
  input  logic               enable,
  output logic               adc_start,
  output logic [CH_BITS-1:0] adc_chan,
  input  logic               adc_ready,
  input  logic [DATA_W-1:0]  adc_data,
  input  logic [CH_BITS-1:0] rd_chan,
  output logic [DATA_W-1:0]  rd_data,
  output logic               rd_valid,
  output logic               sample_strobe,
  output logic               scan_done,
  output logic               timeout_err,
  input  logic               err_clr
);

  localparam int AW    = DATA_W + AVG_LOG2;
  localparam int TW    = $clog2(PERIOD);
  localparam int WW    = $clog2(TIMEOUT + 1);
  localparam int CW    = AVG_LOG2 + 1;
  localparam int NSLOT = 1 << CH_BITS;

  localparam logic [TW-1:0]      PERIOD_M1 = TW'(PERIOD - 1);
  localparam logic [WW-1:0]      TO_M1     = WW'(TIMEOUT - 1);
  localparam logic [CW-1:0]      NCONV     = CW'(1 << AVG_LOG2);
  localparam logic [CH_BITS-1:0] LAST_CH   = CH_BITS'(N_CH - 1);
  localparam logic [CH_BITS:0]   N_CH_X    = (CH_BITS + 1)'(N_CH);

  typedef enum logic [2:0] {IDLE, START, WAIT, PUBLISH, NEXT} state_t;

  state_t              state;
  state_t              state_next;
  logic [TW-1:0]       timer;
  logic                tick;
  logic [CH_BITS-1:0]  chan;
  logic [AW-1:0]       acc;
  logic [CW-1:0]       conv;
  logic [CW-1:0]       conv_inc;
  logic [WW-1:0]       wcnt;
  logic                to_hit;
  logic [DATA_W-1:0]   pub_value;
  logic [DATA_W-1:0]   result [NSLOT];
  logic [NSLOT-1:0]    valid;

  assign tick      = enable && (timer == PERIOD_M1);
  assign conv_inc  = conv + CW'(1);
  assign pub_value = acc[AW-1:AVG_LOG2];
  assign adc_chan  = chan;
  // Last wait cycle elapsed with no answer from the ADC.
  assign to_hit    = (state == WAIT) && !adc_ready && (wcnt == TO_M1);

  // FSM state register.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; enable low forces IDLE from any state.
  always_comb begin
    state_next = state;
    if (!enable) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    state_next = tick ? START : IDLE;
        START:   state_next = WAIT;
        WAIT: begin
          if (adc_ready) begin
            state_next = (conv_inc == NCONV) ? PUBLISH : START;
          end else if (wcnt == TO_M1) begin
            state_next = NEXT;
          end else begin
            state_next = WAIT;
          end
        end
        PUBLISH: state_next = NEXT;
        NEXT:    state_next = (chan == LAST_CH) ? IDLE : START;
        default: state_next = IDLE;
      endcase
    end
  end

  // Moore outputs decoded from the state register only.
  always_comb begin
    adc_start     = 1'b0;
    sample_strobe = 1'b0;
    scan_done     = 1'b0;
    case (state)
      START:   adc_start     = 1'b1;
      PUBLISH: sample_strobe = 1'b1;
      NEXT:    scan_done     = (chan == LAST_CH);
      default: adc_start     = 1'b0;
    endcase
  end

  // Scan timer: free-runs while enabled, held at zero while disabled.
  always_ff @(posedge clk_clk) begin
    if (reset_reset || !enable) begin
      timer <= '0;
    end else if (timer == PERIOD_M1) begin
      timer <= '0;
    end else begin
      timer <= timer + TW'(1);
    end
  end

  // Conversion datapath: accumulator, conversion/wait counters, channel.
  always_ff @(posedge clk_clk) begin
    if (reset_reset || !enable) begin
      acc  <= '0;
      conv <= '0;
      wcnt <= '0;
      chan <= '0;
    end else begin
      case (state)
        START: wcnt <= '0;
        WAIT: begin
          if (adc_ready) begin
            acc  <= acc + AW'(adc_data);
            conv <= conv_inc;
          end else if (wcnt == TO_M1) begin
            // Abandon the channel; partial sum must not leak into the next one.
            acc  <= '0;
            conv <= '0;
          end else begin
            wcnt <= wcnt + WW'(1);
          end
        end
        PUBLISH: begin
          acc  <= '0;
          conv <= '0;
        end
        NEXT:    chan <= (chan == LAST_CH) ? '0 : chan + CH_BITS'(1);
        default: wcnt <= wcnt;
      endcase
    end
  end

  // Result registers and valid bits; a PUBLISH cycle always commits, even if
  // enable drops in that same cycle, so the strobe never lies.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      for (int i = 0; i < NSLOT; i++) begin
        result[i] <= '0;
      end
      valid <= '0;
    end else if (state == PUBLISH) begin
      result[chan] <= pub_value;
      valid[chan]  <= 1'b1;
    end else begin
      valid <= valid;
    end
  end

  // Sticky timeout flag; a new timeout beats a simultaneous clear.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      timeout_err <= 1'b0;
    end else if (to_hit) begin
      timeout_err <= 1'b1;
    end else if (err_clr) begin
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= timeout_err;
    end
  end

  // Registered readback with a bypass for the channel being published now.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else if ({1'b0, rd_chan} >= N_CH_X) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else if ((state == PUBLISH) && (rd_chan == chan)) begin
      rd_data  <= pub_value;
      rd_valid <= 1'b1;
    end else begin
      rd_data  <= result[rd_chan];
      rd_valid <= valid[rd_chan];
    end
  end

endmodule

// File: tb/tb_adc_scan_avg.sv
// Directed self-checking bench for adc_scan_avg (main instance N_CH=4,
// AVG_LOG2=2, PERIOD=100, TIMEOUT=20, plus a small AVG_LOG2=0 instance).
module tb_adc_scan_avg;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       adc_start;
  logic [2:0] adc_chan;
  logic       adc_ready;
  logic [9:0] adc_data;
  logic [2:0] rd_chan = 3'd0;
  logic [9:0] rd_data;
  logic       rd_valid;
  logic       sample_strobe;
  logic       scan_done;
  logic       timeout_err;
  logic       err_clr = 1'b0;

  // ADC model controls
  logic       m_ready = 1'b0;
  logic [9:0] m_data = 10'd0;
  logic       m_pend = 1'b0;
  int         m_dly = 0;
  int         m_k = 0;
  logic       m_mode = 1'b0;      // 0: 100..103 sequence, 1: constant 1023
  int         mute_ch = -1;
  logic       start_ready = 1'b0; // also raise ready (garbage data) during START
  logic       model_clr = 1'b0;

  // AVG_LOG2=0 instance
  logic       b_en = 1'b0;
  logic       b_start;
  logic [0:0] b_chan;
  logic       b_ready = 1'b0;
  logic       b_d1 = 1'b0;
  logic [9:0] b_data = 10'd0;
  logic [0:0] b_rd_chan = 1'b0;
  logic [9:0] b_rd_data;
  logic       b_rd_valid;
  logic       b_strobe;
  logic       b_done;
  logic       b_terr;
  logic       b_clr = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  adc_scan_avg #(.DATA_W(10), .N_CH(4), .CH_BITS(3), .AVG_LOG2(2),
                 .PERIOD(100), .TIMEOUT(20)) dut (
    .clk_clk(clk), .reset_reset(rst), .enable(en),
    .adc_start(adc_start), .adc_chan(adc_chan),
    .adc_ready(adc_ready), .adc_data(adc_data),
    .rd_chan(rd_chan), .rd_data(rd_data), .rd_valid(rd_valid),
    .sample_strobe(sample_strobe), .scan_done(scan_done),
    .timeout_err(timeout_err), .err_clr(err_clr));

  adc_scan_avg #(.DATA_W(10), .N_CH(2), .CH_BITS(1), .AVG_LOG2(0),
                 .PERIOD(10), .TIMEOUT(8)) dut0 (
    .clk_clk(clk), .reset_reset(rst), .enable(b_en),
    .adc_start(b_start), .adc_chan(b_chan),
    .adc_ready(b_ready), .adc_data(b_data),
    .rd_chan(b_rd_chan), .rd_data(b_rd_data), .rd_valid(b_rd_valid),
    .sample_strobe(b_strobe), .scan_done(b_done),
    .timeout_err(b_terr), .err_clr(b_clr));

  // Main ADC model: ready 5 cycles after the START cycle, muted channel never answers.
  always @(posedge clk) begin
    m_ready <= 1'b0;
    if (model_clr) begin
      m_pend <= 1'b0;
      m_k    <= 0;
    end else if (adc_start && (int'(adc_chan) != mute_ch)) begin
      m_pend <= 1'b1;
      m_dly  <= 4;
    end else if (m_pend) begin
      if (m_dly == 1) begin
        m_ready <= 1'b1;
        m_pend  <= 1'b0;
        m_data  <= m_mode ? 10'd1023 : 10'(100 + (m_k % 4));
        m_k     <= m_k + 1;
      end else begin
        m_dly <= m_dly - 1;
      end
    end
  end

  assign adc_ready = m_ready | (start_ready & adc_start);
  assign adc_data  = (start_ready && adc_start) ? 10'd1000 : m_data;

  // Second ADC model: ready two cycles after START, data 700+channel.
  always @(posedge clk) begin
    b_d1    <= b_start;
    b_ready <= b_d1;
    b_data  <= 10'd700 + {9'd0, b_chan};
  end

  task automatic pulse_model_clr();
    @(negedge clk); model_clr = 1'b1;
    @(negedge clk); model_clr = 1'b0;
  endtask

  // Runs until scan_done (bounded) and reports what happened on the way.
  task automatic run_scan(output int first, output int starts, output int strobes,
                          output bit done, output bit to_seen, output int to_lat,
                          output logic [9:0] pd, output logic pv);
    int last_start;
    bit prev_strobe;
    first = 0; starts = 0; strobes = 0; done = 1'b0; to_seen = 1'b0; to_lat = 0;
    pd = 10'd0; pv = 1'b0; last_start = 0; prev_strobe = 1'b0;
    for (int i = 1; i <= 700 && !done; i++) begin
      @(negedge clk);
      if (prev_strobe) begin
        pd = rd_data;
        pv = rd_valid;
      end
      prev_strobe = sample_strobe;
      if (adc_start) begin
        starts++;
        last_start = i;
        if (first == 0) first = i;
      end
      if (sample_strobe) strobes++;
      if (timeout_err && !to_seen) begin
        to_seen = 1'b1;
        to_lat  = i - last_start;
      end
      if (scan_done) done = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; b_en = 1'b0; model_clr = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0; model_clr = 1'b0;
    @(negedge clk);
    checks++;
    if ({adc_start, scan_done, sample_strobe, timeout_err, rd_valid} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 00000",
               {adc_start, scan_done, sample_strobe, timeout_err, rd_valid});
    end
    checks++;
    if (adc_chan !== 3'd0) begin
      errors++; $display("FAIL reset_chan: got %0d expected 0", adc_chan);
    end
    checks++;
    if (rd_data !== 10'd0) begin
      errors++; $display("FAIL reset_rd_data: got %0d expected 0", rd_data);
    end
  endtask

  task automatic test_scan();
    int first, starts, strobes, to_lat, gap;
    bit done, to_seen;
    logic [9:0] pd;
    logic pv;
    rd_chan = 3'd3;
    en = 1'b1;
    run_scan(first, starts, strobes, done, to_seen, to_lat, pd, pv);
    checks++;
    if (first !== 100) begin errors++; $display("FAIL first_start: got %0d expected 100", first); end
    checks++;
    if (!done || starts !== 16) begin errors++; $display("FAIL scan_starts: got %0d done=%0d expected 16", starts, done); end
    checks++;
    if (strobes !== 4) begin errors++; $display("FAIL scan_strobes: got %0d expected 4", strobes); end
    checks++;
    if (pd !== 10'd101 || pv !== 1'b1) begin
      errors++; $display("FAIL publish_bypass: got %0d/%0d expected 101/1", pd, pv);
    end
    gap = 0;
    for (int c = 0; c < 4; c++) begin
      rd_chan = 3'(c);
      @(negedge clk); gap++;
      checks++;
      if (rd_data !== 10'd101 || rd_valid !== 1'b1) begin
        errors++; $display("FAIL read_ch%0d: got %0d/%0d expected 101/1", c, rd_data, rd_valid);
      end
    end
    for (int c = 4; c < 6; c++) begin
      rd_chan = 3'(c);
      @(negedge clk); gap++;
      checks++;
      if (rd_data !== 10'd0 || rd_valid !== 1'b0) begin
        errors++; $display("FAIL read_oob%0d: got %0d/%0d expected 0/0", c, rd_data, rd_valid);
      end
    end
    // Scan is longer than PERIOD: the tick inside the scan is dropped.
    for (int i = 0; i < 300 && !adc_start; i++) begin
      @(negedge clk); gap++;
    end
    checks++;
    if (gap !== 97) begin errors++; $display("FAIL scan_gap: got %0d expected 97", gap); end
    en = 1'b0;
    pulse_model_clr();
  endtask

  task automatic test_start_ready();
    int first, starts, strobes, to_lat;
    bit done, to_seen;
    logic [9:0] pd;
    logic pv;
    start_ready = 1'b1;
    en = 1'b1;
    run_scan(first, starts, strobes, done, to_seen, to_lat, pd, pv);
    checks++;
    if (!done || starts !== 16 || strobes !== 4) begin
      errors++; $display("FAIL start_ready_counts: got starts=%0d strobes=%0d expected 16/4", starts, strobes);
    end
    rd_chan = 3'd1;
    @(negedge clk);
    checks++;
    if (rd_data !== 10'd101) begin errors++; $display("FAIL start_ready_ch1: got %0d expected 101", rd_data); end
    start_ready = 1'b0;
    en = 1'b0;
    pulse_model_clr();
  endtask

  task automatic test_timeout();
    int first, starts, strobes, to_lat;
    bit done, to_seen;
    logic [9:0] pd;
    logic pv;
    logic [9:0] exp_d [4];
    exp_d[0] = 10'd1023; exp_d[1] = 10'd1023; exp_d[2] = 10'd101; exp_d[3] = 10'd1023;
    m_mode = 1'b1; mute_ch = 2;
    en = 1'b1;
    run_scan(first, starts, strobes, done, to_seen, to_lat, pd, pv);
    checks++;
    if (!done || strobes !== 3) begin errors++; $display("FAIL timeout_strobes: got %0d done=%0d expected 3", strobes, done); end
    checks++;
    if (!to_seen || to_lat !== 21) begin errors++; $display("FAIL timeout_latency: got %0d seen=%0d expected 21", to_lat, to_seen); end
    for (int c = 0; c < 4; c++) begin
      rd_chan = 3'(c);
      @(negedge clk);
      checks++;
      if (rd_data !== exp_d[c] || rd_valid !== 1'b1) begin
        errors++; $display("FAIL timeout_read_ch%0d: got %0d/%0d expected %0d/1", c, rd_data, rd_valid, exp_d[c]);
      end
    end
    checks++;
    if (timeout_err !== 1'b1) begin errors++; $display("FAIL timeout_sticky: got %0d expected 1", timeout_err); end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    checks++;
    if (timeout_err !== 1'b0) begin errors++; $display("FAIL err_clr: got %0d expected 0", timeout_err); end
    // Hold err_clr through a whole scan: the set must still be visible.
    en = 1'b0;
    pulse_model_clr();
    err_clr = 1'b1;
    en = 1'b1;
    run_scan(first, starts, strobes, done, to_seen, to_lat, pd, pv);
    checks++;
    if (!to_seen) begin errors++; $display("FAIL set_beats_clear: got seen=%0d expected 1", to_seen); end
    checks++;
    if (timeout_err !== 1'b0) begin errors++; $display("FAIL held_clear: got %0d expected 0", timeout_err); end
    err_clr = 1'b0;
    en = 1'b0;
    mute_ch = -1; m_mode = 1'b0;
    pulse_model_clr();
  endtask

  task automatic test_abort();
    int cyc, first, ch1_starts, strobes, strobes_after;
    // Reset in the middle of a scan wipes results.
    rd_chan = 3'd0;
    en = 1'b1;
    repeat (110) @(negedge clk);
    rst = 1'b1; model_clr = 1'b1;
    @(negedge clk);
    rst = 1'b0; model_clr = 1'b0;
    cyc = 0; first = 0; ch1_starts = 0; strobes = 0;
    for (int i = 0; i < 400 && ch1_starts < 3; i++) begin
      @(negedge clk); cyc++;
      if (cyc == 1) begin
        checks++;
        if (rd_data !== 10'd0 || rd_valid !== 1'b0 || timeout_err !== 1'b0) begin
          errors++; $display("FAIL reset_mid: got %0d/%0d/%0d expected 0/0/0", rd_data, rd_valid, timeout_err);
        end
      end
      if (adc_start && first == 0) first = cyc;
      if (adc_start && adc_chan == 3'd1) ch1_starts++;
      if (sample_strobe) strobes++;
    end
    checks++;
    if (first !== 100 || ch1_starts !== 3) begin
      errors++; $display("FAIL abort_setup: got first=%0d ch1_starts=%0d expected 100/3", first, ch1_starts);
    end
    repeat (2) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    checks++;
    if (adc_chan !== 3'd0 || adc_start !== 1'b0) begin
      errors++; $display("FAIL abort_idle: got chan=%0d start=%0d expected 0/0", adc_chan, adc_start);
    end
    strobes_after = strobes;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (sample_strobe) strobes_after++;
    end
    checks++;
    if (strobes_after !== 1) begin errors++; $display("FAIL abort_strobes: got %0d expected 1", strobes_after); end
    for (int c = 0; c < 2; c++) begin
      rd_chan = 3'(c);
      @(negedge clk);
      checks++;
      if (rd_data !== (c == 0 ? 10'd101 : 10'd0) || rd_valid !== (c == 0)) begin
        errors++; $display("FAIL abort_read_ch%0d: got %0d/%0d expected %0d/%0d", c, rd_data, rd_valid, (c == 0 ? 101 : 0), (c == 0));
      end
    end
    pulse_model_clr();
    en = 1'b1;
    cyc = 0;
    for (int i = 0; i < 300 && !adc_start; i++) begin
      @(negedge clk); cyc++;
    end
    checks++;
    if (cyc !== 100 || adc_chan !== 3'd0) begin
      errors++; $display("FAIL reenable_start: got %0d chan=%0d expected 100/0", cyc, adc_chan);
    end
    en = 1'b0;
    pulse_model_clr();
  endtask

  task automatic test_avg0();
    bit done;
    done = 1'b0;
    b_en = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (b_done) done = 1'b1;
    end
    checks++;
    if (!done) begin errors++; $display("FAIL avg0_done: got 0 expected 1"); end
    for (int c = 0; c < 2; c++) begin
      b_rd_chan = 1'(c);
      @(negedge clk);
      checks++;
      if (b_rd_data !== 10'(700 + c) || b_rd_valid !== 1'b1) begin
        errors++; $display("FAIL avg0_read_ch%0d: got %0d/%0d expected %0d/1", c, b_rd_data, b_rd_valid, 700 + c);
      end
    end
    b_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_scan();
    test_start_ready();
    test_timeout();
    test_abort();
    test_avg0();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
